// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low row at a time, samples the
// synchronised columns at the end of each row dwell and debounces whole scans.
module keypad_scanner #(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned SCAN_HZ        = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi
);

    localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CW  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAND,
        HELD
    } state_t;

    logic [3:0]    col_meta;
    logic [3:0]    col_s;
    logic [PW-1:0] presc;
    logic          tick;
    logic [1:0]    row_idx;
    logic [1:0]    row_next;

    logic [1:0]    acc_hits;
    logic [3:0]    acc_code;
    logic [1:0]    row_hits;
    logic [1:0]    row_first;
    logic [2:0]    hit_sum;
    logic [1:0]    scan_hits;
    logic [3:0]    scan_code;
    logic          scan_done;
    logic          scan_single;

    state_t        state;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] rcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= '1;
            col_s    <= '1;
        end else begin
            col_meta <= col_n;
            col_s    <= col_meta;
        end
    end

    always_comb begin
        tick     = (presc == PRESC_LAST);
        row_next = row_idx + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Press count for the current row (saturating at 2) and its lowest pressed column.
    always_comb begin
        row_hits  = 2'd0;
        row_first = 2'd0;
        for (int unsigned c = 0; c < 4; c++) begin
            if (!col_s[c]) begin
                if (row_hits == 2'd0) begin
                    row_first = 2'(c);
                end
                if (row_hits != 2'd2) begin
                    row_hits = row_hits + 2'd1;
                end
            end
        end
    end

    always_comb begin
        hit_sum     = 3'(acc_hits) + 3'(row_hits);
        scan_hits   = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
        scan_code   = (acc_hits == 2'd0) ? {row_idx, row_first} : acc_code;
        scan_done   = tick && (row_idx == 2'd3);
        scan_single = scan_done && (scan_hits == 2'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_idx  <= 2'd0;
            row_n    <= 4'b1110;
            acc_hits <= 2'd0;
            acc_code <= 4'd0;
            multi    <= 1'b0;
        end else if (tick) begin
            row_idx <= row_next;
            row_n   <= ~(4'b0001 << row_next);
            if (scan_done) begin
                acc_hits <= 2'd0;
                acc_code <= 4'd0;
                multi    <= (scan_hits == 2'd2);
            end else begin
                acc_hits <= scan_hits;
                acc_code <= scan_code;
            end
        end
    end

    // Debounce runs only on scan boundaries; key_valid is a single-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= 4'd0;
            cnt       <= '0;
            rcnt      <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_done) begin
                case (state)
                    IDLE: begin
                        if (scan_single) begin
                            cand <= scan_code;
                            if (DEBOUNCE_SCANS == 1) begin
                                key_code  <= scan_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                rcnt      <= '0;
                                state     <= HELD;
                            end else begin
                                cnt   <= CW'(1);
                                state <= CAND;
                            end
                        end
                    end
                    CAND: begin
                        if (scan_single && (scan_code == cand)) begin
                            if (cnt == CNT_LAST) begin
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                rcnt      <= '0;
                                cnt       <= '0;
                                state     <= HELD;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else if (scan_single) begin
                            cand <= scan_code;
                            cnt  <= CW'(1);
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end
                    HELD: begin
                        if (scan_single && (scan_code == cand)) begin
                            rcnt <= '0;
                        end else if (rcnt == CNT_LAST) begin
                            key_held <= 1'b0;
                            rcnt     <= '0;
                            state    <= IDLE;
                        end else begin
                            rcnt <= rcnt + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a key-matrix model feeds col_n from row_n.
module tb_keypad_scanner;

    localparam int unsigned SCAN_CLKS = 16;

    logic       clk;
    logic       rst_n;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multi;

    logic [15:0] keys;
    logic        rand_en;
    logic [3:0]  col_rand;
    logic [3:0]  col_model;

    int n_checks;
    int n_fail;
    int valid_count;

    keypad_scanner #(
        .CLK_HZ(16),
        .SCAN_HZ(4),
        .DEBOUNCE_SCANS(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .col_n(col_n),
        .row_n(row_n),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held),
        .multi(multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed key at (r,c) pulls column c low while row r is driven low.
    always_comb begin
        col_model = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_n[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r*4+c]) col_model[c] = 1'b0;
                end
            end
        end
    end
    assign col_n = rand_en ? col_rand : col_model;

    always @(negedge clk) begin
        if (key_valid === 1'b1) valid_count = valid_count + 1;
    end

    task automatic run_clks(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_scans(input int n);
        run_clks(n * SCAN_CLKS);
    endtask

    task automatic test_reset;
        logic [3:0] exp_rows [5];
        exp_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst_n   = 1'b0;
        rand_en = 1'b1;
        keys    = '0;
        for (int i = 0; i < 4; i++) begin
            col_rand = 4'($urandom);
            @(negedge clk);
        end
        n_checks++; if (row_n !== 4'b1110) begin n_fail++; $display("FAIL reset_row_n: got %b want 1110", row_n); end
        n_checks++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL reset_key_code: got %0d want 0", key_code); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_key_held: got %b want 0", key_held); end
        n_checks++; if (multi !== 1'b0) begin n_fail++; $display("FAIL reset_multi: got %b want 0", multi); end
        rand_en = 1'b0;
        rst_n   = 1'b1;
        n_checks++; if (row_n !== exp_rows[0]) begin n_fail++; $display("FAIL row_seq0: got %b want %b", row_n, exp_rows[0]); end
        for (int i = 1; i < 5; i++) begin
            run_clks(4);
            n_checks++;
            if (row_n !== exp_rows[i]) begin
                n_fail++;
                $display("FAIL row_seq%0d: got %b want %b", i, row_n, exp_rows[i]);
            end
        end
    endtask

    task automatic test_single_key;
        int vc0;
        vc0  = valid_count;
        keys = 16'h0200;
        run_scans(3);
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL single_early_held: got %b want 0", key_held); end
        n_checks++; if (valid_count !== vc0) begin n_fail++; $display("FAIL single_early_valid: got %0d pulses want 0", valid_count - vc0); end
        run_scans(1);
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", key_valid); end
        n_checks++; if (key_code !== 4'd9) begin n_fail++; $display("FAIL single_code: got %0d want 9", key_code); end
        n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL single_held: got %b want 1", key_held); end
        run_scans(1);
        n_checks++; if (valid_count !== vc0 + 1) begin n_fail++; $display("FAIL single_pulses: got %0d want 1", valid_count - vc0); end
        keys = '0;
        run_scans(3);
        n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL single_rel3_held: got %b want 1", key_held); end
        run_scans(1);
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL single_rel4_held: got %b want 0", key_held); end
        n_checks++; if (valid_count !== vc0 + 1) begin n_fail++; $display("FAIL single_total_pulses: got %0d want 1", valid_count - vc0); end
    endtask

    task automatic test_bounce;
        int vc0;
        vc0  = valid_count;
        keys = 16'h0008;
        run_scans(2);
        keys = '0;
        run_scans(1);
        keys = 16'h0008;
        run_scans(2);
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL bounce_mid_held: got %b want 0", key_held); end
        keys = '0;
        run_scans(2);
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL bounce_held: got %b want 0", key_held); end
        n_checks++; if (valid_count !== vc0) begin n_fail++; $display("FAIL bounce_pulses: got %0d want 0", valid_count - vc0); end
    endtask

    task automatic test_multi;
        int vc0;
        vc0  = valid_count;
        keys = 16'h8001;
        run_scans(1);
        n_checks++; if (multi !== 1'b1) begin n_fail++; $display("FAIL multi_first: got %b want 1", multi); end
        run_scans(5);
        n_checks++; if (multi !== 1'b1) begin n_fail++; $display("FAIL multi_hold: got %b want 1", multi); end
        n_checks++; if (valid_count !== vc0) begin n_fail++; $display("FAIL multi_pulses: got %0d want 0", valid_count - vc0); end
        keys = 16'h8000;
        run_scans(1);
        n_checks++; if (multi !== 1'b0) begin n_fail++; $display("FAIL multi_clear: got %b want 0", multi); end
        run_scans(3);
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL multi_then_valid: got %b want 1", key_valid); end
        n_checks++; if (key_code !== 4'd15) begin n_fail++; $display("FAIL multi_then_code: got %0d want 15", key_code); end
        keys = '0;
        run_scans(4);
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL multi_release: got %b want 0", key_held); end
    endtask

    task automatic test_release;
        int vc0;
        vc0  = valid_count;
        keys = 16'h0020;
        run_scans(4);
        n_checks++; if (key_code !== 4'd5) begin n_fail++; $display("FAIL rel_code: got %0d want 5", key_code); end
        n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL rel_accept_held: got %b want 1", key_held); end
        keys = '0;
        run_scans(2);
        n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL rel_glitch_held: got %b want 1", key_held); end
        keys = 16'h0020;
        run_scans(1);
        n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL rel_repress_held: got %b want 1", key_held); end
        keys = '0;
        run_clks(3 * SCAN_CLKS + SCAN_CLKS - 1);
        n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL rel_before_edge: got %b want 1", key_held); end
        run_clks(1);
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL rel_at_edge: got %b want 0", key_held); end
        n_checks++; if (valid_count !== vc0 + 1) begin n_fail++; $display("FAIL rel_pulses: got %0d want 1", valid_count - vc0); end
    endtask

    task automatic test_async_reset;
        int vc0;
        keys = 16'h0020;
        run_scans(3);
        run_clks(5);
        rst_n = 1'b0;
        #1;
        n_checks++; if (row_n !== 4'b1110) begin n_fail++; $display("FAIL cand_rst_row_n: got %b want 1110", row_n); end
        n_checks++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL cand_rst_code: got %0d want 0", key_code); end
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL cand_rst_held: got %b want 0", key_held); end
        keys = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        vc0 = valid_count;
        run_scans(5);
        n_checks++; if (valid_count !== vc0) begin n_fail++; $display("FAIL cand_rst_pulses: got %0d want 0", valid_count - vc0); end
        n_checks++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL cand_rst_code_after: got %0d want 0", key_code); end

        vc0  = valid_count;
        keys = 16'h0020;
        run_scans(5);
        n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL held_pre_rst: got %b want 1", key_held); end
        n_checks++; if (valid_count !== vc0 + 1) begin n_fail++; $display("FAIL held_pre_pulses: got %0d want 1", valid_count - vc0); end
        run_clks(7);
        rst_n = 1'b0;
        #1;
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL held_rst_held: got %b want 0", key_held); end
        n_checks++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL held_rst_code: got %0d want 0", key_code); end
        n_checks++; if (row_n !== 4'b1110) begin n_fail++; $display("FAIL held_rst_row_n: got %b want 1110", row_n); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL held_rst_valid: got %b want 0", key_valid); end
        keys = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        vc0 = valid_count;
        run_scans(5);
        n_checks++; if (valid_count !== vc0) begin n_fail++; $display("FAIL held_rst_pulses: got %0d want 0", valid_count - vc0); end
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL held_rst_held_after: got %b want 0", key_held); end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        valid_count = 0;
        rst_n       = 1'b0;
        rand_en     = 1'b1;
        col_rand    = 4'hF;
        keys        = '0;
        test_reset();
        test_single_key();
        test_bounce();
        test_multi();
        test_release();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
